// File: rtl/add_operand_loader.sv
// add_operand_loader
//   Feeds a registered WIDTH-bit adder. Operand bytes arrive little-endian over
//   a valid/ready link. Operand A is assembled first, then operand B, in shadow
//   registers. Both operands are committed to A/B on the edge that accepts the
//   last B byte. en then pulses for one cycle so the adder registers A+B.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din        operand byte
//   din_valid  din holds a byte
//   din_ready  byte can be accepted this cycle (low only while issuing)
//   clr        synchronous abort of a partial frame
//   A, B       committed operands (WIDTH bits each)
//   en         one-cycle issue strobe to the adder
//   busy       frame in progress or issuing
//   op_cnt     number of issued operations, modulo 256
module add_operand_loader #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             en,
  output logic             busy,
  output logic [7:0]       op_cnt
);

  localparam int NBYTES = (WIDTH + 7) / 8;
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ISSUE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_idx;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [7:0]       r_op_cnt;

  logic             w_ready;
  logic             w_xfer;
  logic             w_last;
  logic             w_wr_a;
  logic             w_wr_b;
  logic [WIDTH-1:0] w_sh_a_new;
  logic [WIDTH-1:0] w_sh_b_new;

  assign w_ready = (r_state != S_ISSUE);
  assign w_xfer  = din_valid && w_ready;
  assign w_last  = (r_idx == LAST_IDX);
  // IDLE accepts byte 0 of A, so it writes the A shadow like LOAD_A.
  assign w_wr_a  = (r_state == S_IDLE) || (r_state == S_LOAD_A);
  assign w_wr_b  = (r_state == S_LOAD_B);

  // Byte lanes of the shadows. The top lane is narrower when WIDTH is not a
  // multiple of 8; the excess din bits are simply dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      localparam int LW = ((WIDTH - 8 * gi) < 8) ? (WIDTH - 8 * gi) : 8;
      logic w_sel;
      assign w_sel = (r_idx == 2'(gi));
      assign w_sh_a_new[8*gi +: LW] = (w_wr_a && w_sel) ? din[LW-1:0] : r_sh_a[8*gi +: LW];
      assign w_sh_b_new[8*gi +: LW] = (w_wr_b && w_sel) ? din[LW-1:0] : r_sh_b[8*gi +: LW];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (clr)         w_state_next = S_IDLE;
        else if (w_xfer) w_state_next = (NBYTES == 1) ? S_LOAD_B : S_LOAD_A;
      end
      S_LOAD_A: begin
        if (clr)                   w_state_next = S_IDLE;
        else if (w_xfer && w_last) w_state_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        if (clr)                   w_state_next = S_IDLE;
        else if (w_xfer && w_last) w_state_next = S_ISSUE;
      end
      S_ISSUE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      // Commit already happened; clr cannot cancel an issued operation.
      r_op_cnt <= r_op_cnt + 8'd1;
      r_idx    <= '0;
    end else if (clr) begin
      r_idx  <= '0;
      r_sh_a <= '0;
      r_sh_b <= '0;
    end else if (w_xfer) begin
      r_sh_a <= w_sh_a_new;
      r_sh_b <= w_sh_b_new;
      r_idx  <= w_last ? 2'd0 : r_idx + 2'd1;
      // Final B byte: B takes the shadow including the byte arriving now.
      if (w_wr_b && w_last) begin
        r_a <= r_sh_a;
        r_b <= w_sh_b_new;
      end
    end
  end

  assign din_ready = w_ready;
  assign en        = (r_state == S_ISSUE);
  assign busy      = (r_state != S_IDLE);
  assign A         = r_a;
  assign B         = r_b;
  assign op_cnt    = r_op_cnt;

endmodule
